qnet_div_seq: RTL and testbench
===============================

Name: qnet_div_seq

Overview:
- Request sequencer placed directly upstream of the team's unsigned pipelined divider (start/ready/end interface).
- Accepts signed or unsigned division requests on a valid/ready channel and converts operands to magnitudes.
- Drives the divider's start, collects quotient/remainder on its end pulse, applies sign correction, and presents the result on a valid/ready output channel with a tag.
- Handles divide-by-zero locally without using the divider, and watches for a hung divider with a timeout.

Parameters:
- DW, 32, operand/result width; must equal divider DW.
- N_PIPE, 32, divider register stages; sets the timeout bound.
- TAGW, 4, width of the request tag carried through to the result.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
- in_a_i  in  DW  dividend
- in_b_i  in  DW  divisor
- in_signed_i  in  1  1: two's-complement operands; 0: unsigned
- in_tag_i  in  TAGW  request tag
- div_start_o  out  1  start pulse to divider
- div_a_o  out  DW  dividend magnitude to divider
- div_b_o  out  DW  divisor magnitude to divider
- div_ready_i  in  1  divider idle
- div_end_i  in  1  divider result valid (1 cycle)
- div_quotient_i  in  DW  unsigned quotient
- div_remainder_i  in  DW  unsigned remainder
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o & out_ready_i
- out_quotient_o  out  DW  signed-corrected quotient
- out_remainder_o  out  DW  signed-corrected remainder
- out_tag_o  out  TAGW  tag of the request
- out_dz_o  out  1  result came from divide-by-zero
- out_err_o  out  1  result came from timeout
- err_timeout_o  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state IDLE; all outputs 0, except in_ready_o, which follows IDLE (1 once rst_ni deasserts).
  - Reset mid-operation abandons the request silently. The divider shares rst_ni.
- States and transitions:
  - IDLE: in_ready_o=1. On accept, register operands, sign bits and tag.
    - Divisor b==0: go to RESULT with q=all-ones, r=a (raw input bits), out_dz_o=1.
    - Otherwise: go to ISSUE with div_a_o=|a|, div_b_o=|b| (abs only when in_signed_i).
  - ISSUE: div_start_o = div_ready_i (combinational, single cycle). On div_ready_i=1 go to WAIT and clear the watchdog. div_a_o/div_b_o are held from the accept cycle until the next accept.
  - WAIT: the watchdog increments each cycle.
    - On div_end_i=1, capture the corrected results and go to RESULT.
    - If the watchdog reaches N_PIPE+4 first: go to RESULT with q=r=0, out_err_o=1, and set err_timeout_o.
  - RESULT: out_valid_o=1 and output fields are stable. On out_ready_i go to IDLE.
- Throughput and latency:
  - One request in flight; in_ready_o=0 outside IDLE.
  - With the team divider and div_ready_i=1, out_valid_o rises N_PIPE+1 cycles after the accept edge.
  - Divide-by-zero results appear 1 cycle after accept.
- Sign correction (signed mode only):
  - q is negated iff sign(a) XOR sign(b).
  - r is negated iff sign(a), so truncation is toward zero and the remainder takes the dividend's sign.
  - Overflow case: most-negative / -1 gives q=most-negative (wrap) and r=0. This falls out of the magnitude path with no special case.
  - Unsigned mode passes the divider results through unchanged.
- div_end_i outside WAIT is ignored.
- in_valid_i may drop before acceptance; the block has no obligation to hold it.
- Once out_valid_o is high, it and all output fields stay stable until accepted, including under out_ready_i toggling.

Decomposition:
- Shared package qnet_div_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESULT}
  - request struct {a, b, signed, tag}
  - result struct {q, r, tag, dz, err}
  - constant TIMEOUT_EXTRA=4
- Sub-module qnet_div_sign: combinational abs/negate helper, instantiated twice (operand magnitudes, result correction).

Test Plan:
- Unsigned 100/7, tag 3 -> q=14, r=2, tag 3, dz=0; out_valid_o 33 cycles after accept (N_PIPE=32).
- Signed -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Signed 7/-2 -> q=-3, r=1.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, err=0.
- b=0, a=0x1234 (signed and unsigned) -> q=0xFFFFFFFF, r=0x1234, dz=1 one cycle after accept; div_start_o never asserted.
- Divider model never raises div_end_i -> after 36 WAIT cycles out_err_o=1, q=r=0, err_timeout_o stays 1; next request still completes normally.
- Back-pressure and reset:
  - Hold out_ready_i=0 for 10 cycles: outputs stable, in_ready_o=0.
  - Assert rst_ni low in WAIT: all outputs 0 immediately, returns to IDLE.

Source files
------------

// File: rtl/qnet_div_pkg.sv
// Shared types and constants for the divider request sequencer.
package qnet_div_pkg;

  // Widths the request/result structs are built with; the sequencer's DW and
  // TAGW parameters must stay equal to these.
  localparam int QNET_DW   = 32;
  localparam int QNET_TAGW = 4;

  // Cycles of slack allowed beyond the divider pipeline depth before the
  // watchdog declares the divider hung.
  localparam int TIMEOUT_EXTRA = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_RESULT = 2'd3;

  typedef struct packed {
    logic [QNET_DW-1:0]   a;
    logic [QNET_DW-1:0]   b;
    logic                 sgn;
    logic [QNET_TAGW-1:0] tag;
  } div_req_t;

  typedef struct packed {
    logic [QNET_DW-1:0]   q;
    logic [QNET_DW-1:0]   r;
    logic [QNET_TAGW-1:0] tag;
    logic                 dz;
    logic                 err;
  } div_res_t;

endpackage

// File: rtl/qnet_div_sign.sv
// Conditional two's-complement negate of two values. Used both to take
// operand magnitudes and to restore signs on the divider results.
module qnet_div_sign #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          neg_a_i,
  input  logic          neg_b_i,
  output logic [DW-1:0] y_a_o,
  output logic [DW-1:0] y_b_o
);

  // Negating the most-negative value wraps to itself, which is exactly what
  // the overflow case (min / -1) needs, so no special handling is required.
  assign y_a_o = neg_a_i ? -a_i : a_i;
  assign y_b_o = neg_b_i ? -b_i : b_i;

endmodule

// File: rtl/qnet_div_seq.sv
// Request sequencer in front of the unsigned pipelined divider: takes signed
// or unsigned requests, feeds magnitudes to the divider, sign-corrects the
// results, handles divide-by-zero locally and times out a hung divider.
//
// state  | meaning
// IDLE   | ready for a request
// ISSUE  | magnitudes on div_a_o/div_b_o, waiting for divider to take start
// WAIT   | divider busy, watchdog running
// RESULT | result held on the output channel until consumed
module qnet_div_seq
  import qnet_div_pkg::*;
#(
  parameter int DW     = QNET_DW,
  parameter int N_PIPE = 32,
  parameter int TAGW   = QNET_TAGW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   in_a_i,
  input  logic [DW-1:0]   in_b_i,
  input  logic            in_signed_i,
  input  logic [TAGW-1:0] in_tag_i,
  output logic            div_start_o,
  output logic [DW-1:0]   div_a_o,
  output logic [DW-1:0]   div_b_o,
  input  logic            div_ready_i,
  input  logic            div_end_i,
  input  logic [DW-1:0]   div_quotient_i,
  input  logic [DW-1:0]   div_remainder_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   out_quotient_o,
  output logic [DW-1:0]   out_remainder_o,
  output logic [TAGW-1:0] out_tag_o,
  output logic            out_dz_o,
  output logic            out_err_o,
  output logic            err_timeout_o
);

  localparam int TO_LAST = N_PIPE + TIMEOUT_EXTRA - 1;
  localparam int WDW     = $clog2(N_PIPE + TIMEOUT_EXTRA + 1);

  state_t          state_q;
  div_req_t        req;
  div_res_t        res_q;
  logic [DW-1:0]   div_a_q;
  logic [DW-1:0]   div_b_q;
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  logic [DW-1:0]   cor_q;
  logic [DW-1:0]   cor_r;
  logic            neg_q_q;
  logic            neg_r_q;
  logic [TAGW-1:0] tag_q;
  logic [WDW-1:0]  wdog_q;
  logic            err_to_q;
  logic            accept;

  assign req = '{a: in_a_i, b: in_b_i, sgn: in_signed_i, tag: in_tag_i};

  qnet_div_sign #(.DW(DW)) u_opnd_mag (
    .a_i     (req.a),
    .b_i     (req.b),
    .neg_a_i (req.sgn & req.a[DW-1]),
    .neg_b_i (req.sgn & req.b[DW-1]),
    .y_a_o   (mag_a),
    .y_b_o   (mag_b)
  );

  qnet_div_sign #(.DW(DW)) u_res_fix (
    .a_i     (div_quotient_i),
    .b_i     (div_remainder_i),
    .neg_a_i (neg_q_q),
    .neg_b_i (neg_r_q),
    .y_a_o   (cor_q),
    .y_b_o   (cor_r)
  );

  // Ready is gated by reset so nothing looks acceptable while held in reset.
  assign in_ready_o  = (state_q == ST_IDLE) & rst_ni;
  assign accept      = in_valid_i & in_ready_o;
  assign div_start_o = (state_q == ST_ISSUE) & div_ready_i;
  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;

  assign out_valid_o     = (state_q == ST_RESULT);
  assign out_quotient_o  = res_q.q;
  assign out_remainder_o = res_q.r;
  assign out_tag_o       = res_q.tag;
  assign out_dz_o        = res_q.dz;
  assign out_err_o       = res_q.err;
  assign err_timeout_o   = err_to_q;

  // Request sequencing, watchdog and result capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      div_a_q  <= '0;
      div_b_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      tag_q    <= '0;
      wdog_q   <= '0;
      res_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            div_a_q <= mag_a;
            div_b_q <= mag_b;
            neg_q_q <= req.sgn & (req.a[DW-1] ^ req.b[DW-1]);
            neg_r_q <= req.sgn & req.a[DW-1];
            tag_q   <= req.tag;
            if (req.b == '0) begin
              res_q   <= '{q: {DW{1'b1}}, r: req.a, tag: req.tag, dz: 1'b1, err: 1'b0};
              state_q <= ST_RESULT;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (div_ready_i) begin
            wdog_q  <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_end_i) begin
            res_q   <= '{q: cor_q, r: cor_r, tag: tag_q, dz: 1'b0, err: 1'b0};
            state_q <= ST_RESULT;
          end else if (wdog_q == WDW'(TO_LAST)) begin
            res_q    <= '{q: '0, r: '0, tag: tag_q, dz: 1'b0, err: 1'b1};
            err_to_q <= 1'b1;
            state_q  <= ST_RESULT;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        ST_RESULT: begin
          if (out_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qnet_div_seq.sv
// Directed bench for qnet_div_seq with a behavioural divider model.
// Latency figures are counted from the cycle in which the request handshake
// completes (1 = the cycle right after it).
module tb_qnet_div_seq;

  localparam int DW     = 32;
  localparam int N_PIPE = 32;
  localparam int TAGW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [DW-1:0]   in_a_i;
  logic [DW-1:0]   in_b_i;
  logic            in_signed_i;
  logic [TAGW-1:0] in_tag_i;
  logic            div_start_o;
  logic [DW-1:0]   div_a_o;
  logic [DW-1:0]   div_b_o;
  logic            div_ready_i;
  logic            div_end_i;
  logic [DW-1:0]   div_quotient_i;
  logic [DW-1:0]   div_remainder_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   out_quotient_o;
  logic [DW-1:0]   out_remainder_o;
  logic [TAGW-1:0] out_tag_o;
  logic            out_dz_o;
  logic            out_err_o;
  logic            err_timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  qnet_div_seq #(.DW(DW), .N_PIPE(N_PIPE), .TAGW(TAGW)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_a_i          (in_a_i),
    .in_b_i          (in_b_i),
    .in_signed_i     (in_signed_i),
    .in_tag_i        (in_tag_i),
    .div_start_o     (div_start_o),
    .div_a_o         (div_a_o),
    .div_b_o         (div_b_o),
    .div_ready_i     (div_ready_i),
    .div_end_i       (div_end_i),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_quotient_o  (out_quotient_o),
    .out_remainder_o (out_remainder_o),
    .out_tag_o       (out_tag_o),
    .out_dz_o        (out_dz_o),
    .out_err_o       (out_err_o),
    .err_timeout_o   (err_timeout_o)
  );

  // Divider model: always ready, end pulse N_PIPE-1 cycles after the start
  // cycle; 'hang' suppresses the end pulse, 'spur_end' injects a stray one.
  logic [N_PIPE-2:0] vld;
  logic [DW-1:0]     m_q, m_r;
  logic              hang, spur_end;

  assign div_ready_i     = 1'b1;
  assign div_end_i       = (vld[N_PIPE-2] & ~hang) | spur_end;
  assign div_quotient_i  = m_q;
  assign div_remainder_i = m_r;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= '0;
      m_q <= '0;
      m_r <= '0;
    end else begin
      vld <= {vld[N_PIPE-3:0], div_start_o};
      if (div_start_o) begin
        m_q <= (div_b_o != 0) ? div_a_o / div_b_o : '1;
        m_r <= (div_b_o != 0) ? div_a_o % div_b_o : div_a_o;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sgn, input logic [TAGW-1:0] tag,
                         input logic [DW-1:0] eq, input logic [DW-1:0] er,
                         input logic edz, input logic eerr, input int elat,
                         input logic [DW-1:0] eda, input logic [DW-1:0] edb, input int hold);
    int lat;
    bit seen_start;
    @(negedge clk_i);
    in_a_i = a; in_b_i = b; in_signed_i = sgn; in_tag_i = tag; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0; in_a_i = 32'hDEAD_BEEF; in_b_i = '0; in_signed_i = ~sgn; in_tag_i = ~tag;
    lat = 1;
    seen_start = 1'b0;
    while (lat <= 100) begin
      @(negedge clk_i);
      if (div_start_o) seen_start = 1'b1;
      if (lat == 1) begin
        chk({nm, ".in_ready_busy"}, in_ready_o, 0);
        chk({nm, ".div_a"}, div_a_o, eda);
        chk({nm, ".div_b"}, div_b_o, edb);
      end
      if (out_valid_o) break;
      lat++;
    end
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".q"}, out_quotient_o, eq);
    chk({nm, ".r"}, out_remainder_o, er);
    chk({nm, ".tag"}, out_tag_o, tag);
    chk({nm, ".dz"}, out_dz_o, edz);
    chk({nm, ".err"}, out_err_o, eerr);
    chk({nm, ".start_seen"}, seen_start, !edz);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk({nm, ".hold_valid"}, out_valid_o, 1);
      chk({nm, ".hold_q"}, out_quotient_o, eq);
      chk({nm, ".hold_r"}, out_remainder_o, er);
      chk({nm, ".hold_in_ready"}, in_ready_o, 0);
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    chk({nm, ".back_idle"}, in_ready_o, 1);
    chk({nm, ".valid_drop"}, out_valid_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; in_signed_i = 1'b0;
    in_tag_i = '0; out_ready_i = 1'b0; hang = 1'b0; spur_end = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst.in_ready", in_ready_o, 0);
    chk("rst.out_valid", out_valid_o, 0);
    chk("rst.div_start", div_start_o, 0);
    chk("rst.err_timeout", err_timeout_o, 0);
    chk("rst.q", out_quotient_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rel.in_ready", in_ready_o, 1);

    run_req("u100_7", 100, 7, 0, 3, 14, 2, 0, 0, 33, 100, 7, 10);
    run_req("s_m7_2", 32'hFFFF_FFF9, 2, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 33, 7, 2, 0);
    run_req("s_7_m2", 7, 32'hFFFF_FFFE, 1, 2, 32'hFFFF_FFFD, 1, 0, 0, 33, 7, 2, 0);
    run_req("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 4, 32'h8000_0000, 0, 0, 0, 33,
            32'h8000_0000, 1, 0);
    run_req("u_big", 32'hFFFF_FFF9, 2, 0, 5, 32'h7FFF_FFFC, 1, 0, 0, 33, 32'hFFFF_FFF9, 2, 0);
    run_req("dz_s", 32'h1234, 0, 1, 6, 32'hFFFF_FFFF, 32'h1234, 1, 0, 1, 32'h1234, 0, 0);
    run_req("dz_u", 32'h1234, 0, 0, 7, 32'hFFFF_FFFF, 32'h1234, 1, 0, 1, 32'h1234, 0, 0);
    run_req("dz_neg", 32'hFFFF_FF00, 0, 1, 8, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1, 0, 1,
            32'h100, 0, 0);

    @(negedge clk_i);
    spur_end = 1'b1;
    @(negedge clk_i);
    spur_end = 1'b0;
    chk("spur.out_valid", out_valid_o, 0);
    chk("spur.in_ready", in_ready_o, 1);

    hang = 1'b1;
    run_req("timeout", 50, 5, 0, 9, 0, 0, 0, 1, 38, 50, 5, 0);
    hang = 1'b0;
    chk("timeout.sticky", err_timeout_o, 1);
    run_req("after_to", 50, 5, 0, 10, 10, 0, 0, 0, 33, 50, 5, 0);
    chk("after_to.sticky", err_timeout_o, 1);

    @(negedge clk_i);
    in_a_i = 50; in_b_i = 5; in_signed_i = 1'b0; in_tag_i = 4'hC; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid_o, 0);
    chk("midrst.in_ready", in_ready_o, 0);
    chk("midrst.div_a", div_a_o, 0);
    chk("midrst.err_timeout", err_timeout_o, 0);
    chk("midrst.q", out_quotient_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("midrst.rel_ready", in_ready_o, 1);
    repeat (40) @(negedge clk_i);
    chk("midrst.no_stale", out_valid_o, 0);
    run_req("post_rst", 100, 7, 0, 4'hF, 14, 2, 0, 0, 33, 100, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
